alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares a single 32-bit ALU between NREQ requesters (e.g. pipeline, DMA address
//  calc, debug unit). Round-robin grant, valid/ready handshake on both request and
//  response sides. Operands are registered and each requester has its own held
//  result slot. Sits between the requesters and one ALU instance.
// PARAMETERS
//  NREQ   2   number of requesters, 2..8; index 0 has first priority out of reset
// PORTS
//  CLK          in   1          single clock; all state updates on rising edge
//  RST          in   1          synchronous, active-high reset
//  req_valid    in   NREQ       requester i presents an operation
//  req_ready    out  NREQ       one-hot or zero; accept strobe for requester i
//  req_srcA     in   NREQx32    operand A per requester
//  req_srcB     in   NREQx32    operand B per requester
//  req_fun      in   NREQx4     alu_fun encoding per requester (alu_pkg)
//  resp_valid   out  NREQ       result slot i holds an unconsumed result
//  resp_ready   in   NREQ       requester i consumes its result
//  resp_result  out  NREQx32    held result per requester
//  busy         out  1          FSM is in EXEC
// BEHAVIOUR
//  Reset: req_ready=0, resp_valid=0, resp_result=0, busy=0, state=IDLE,
//   rr_last=NREQ-1. Reset at any time drops any in-flight op and pending results.
//  Eligibility: elig[i] = req_valid[i] & ~resp_valid[i] (registered flag only; a
//   slot freed in cycle t makes requester i eligible from cycle t+1).
//  FSM states IDLE, EXEC:
//   IDLE: if any elig, grant g = first eligible index searching rr_last+1, +2, ...
//    mod NREQ. req_ready[g]=1 combinationally this cycle only. On edge: latch
//    srcA/srcB/fun/g into op regs, rr_last<=g, state<=EXEC. No elig -> stay IDLE,
//    req_ready=0.
//   EXEC: req_ready=0, busy=1. ALU evaluates latched operands combinationally; on
//    edge: resp_result[g]<=alu_result, resp_valid[g]<=1, state<=IDLE.
//  Latency: accept edge at end of cycle N -> resp_valid[g]=1 in cycle N+2.
//   Throughput: one op per 2 cycles, shared across all requesters.
//  Response: resp_valid[i] & resp_ready[i] at edge -> resp_valid[i]<=0;
//   resp_result[i] holds its value until the next write to slot i. Write and
//   consume of the same slot in one cycle cannot occur (slot pending blocks grant).
//  req_valid may drop before acceptance; no penalty. Inputs of requester i are
//   sampled only in the cycle req_ready[i]=1.
//  Undefined fun codes pass through; ALU yields 0 and the result is delivered
//   normally.
//  Arithmetic: 32-bit wrap on ADD/SUB; shifts use srcB[4:0]; SLT signed, SLTU
//   unsigned; LUI-copy = {srcA[31:12],12'b0}.
// STRUCTURE
//  alu_pkg: alu_fun_t enum (ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100,
//   SRL=0101, OR=0110, AND=0111, SUB=1000, LUI=1001, SRA=1101); state_t {IDLE,EXEC}.
//  One sub-module: the existing ALU, instantiated once on the latched operands.
//  Round-robin pick is a function in this file; no separate module.
// TESTING
//  1 Reset, req0 ADD 5+7 -> req_ready[0] one cycle, resp_valid[0]=1 two cycles
//    later, resp_result[0]=12; held until resp_ready[0].
//  2 req0 and req1 valid every cycle, resp_ready=1 -> grants alternate 0,1,0,1;
//    req1 SUB 3-5 -> 0xFFFFFFFE.
//  3 req1 result unconsumed (resp_ready[1]=0), both valid -> only req0 granted
//    repeatedly; raising resp_ready[1] -> req1 granted no earlier than next cycle.
//  4 SRA 0x80000000 by 0x24 (shift 4) -> 0xF8000000; SLT -1<1 -> 1; SLTU -1<1 -> 0.
//  5 RST asserted in EXEC -> next cycle all resp_valid=0, state IDLE, req0 granted
//    first on next request.
//  6 fun=4'b1111 -> result 0 delivered; req_valid dropped before grant -> no response.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and widths for the ALU-sharing arbiter: ALU function codes and FSM states.
package alu_share_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int FUN_W  = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared-ALU arbiter.
interface alu_share_arbiter_if
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][DATA_W-1:0] req_srca;
    logic [NREQ-1:0][DATA_W-1:0] req_srcb;
    logic [NREQ-1:0][FUN_W-1:0]  req_fun;
    logic [NREQ-1:0]             resp_valid;
    logic [NREQ-1:0]             resp_ready;
    logic [NREQ-1:0][DATA_W-1:0] resp_result;

    modport master (
        output req_valid, req_srca, req_srcb, req_fun, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_srca, req_srcb, req_fun, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU; unknown function codes produce zero.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] srca,
    input  logic [DATA_W-1:0] srcb,
    input  logic [FUN_W-1:0]  fun,
    output logic [DATA_W-1:0] result
);

    // Function decode; shift amounts come from the low five bits of srcb.
    always_comb begin
        result = {DATA_W{1'b0}};
        case (fun)
            ALU_ADD:  result = srca + srcb;
            ALU_SLL:  result = srca << srcb[4:0];
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (srca < srcb)};
            ALU_XOR:  result = srca ^ srcb;
            ALU_SRL:  result = srca >> srcb[4:0];
            ALU_OR:   result = srca | srcb;
            ALU_AND:  result = srca & srcb;
            ALU_SUB:  result = srca - srcb;
            ALU_LUI:  result = {srca[31:12], 12'h000};
            ALU_SRA:  result = $signed(srca) >>> srcb[4:0];
            default:  result = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, with a held result slot
// per requester. One operation every two cycles: accept in IDLE, evaluate in EXEC.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2
)
(
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus,
    output logic                 busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t                      state_r;
    logic [IDXW-1:0]             rr_last_r;
    logic [IDXW-1:0]             op_idx_r;
    logic [DATA_W-1:0]           op_srca_r;
    logic [DATA_W-1:0]           op_srcb_r;
    logic [FUN_W-1:0]            op_fun_r;
    logic [NREQ-1:0]             resp_valid_r;
    logic [NREQ-1:0][DATA_W-1:0] resp_result_r;
    logic                        busy_r;

    logic [NREQ-1:0]             elig_s;
    logic [IDXW:0]               pick_s;
    logic                        grant_ok_s;
    logic [IDXW-1:0]             grant_s;
    logic [NREQ-1:0]             req_ready_s;
    logic [DATA_W-1:0]           alu_result_s;

    // First eligible index after 'last', wrapping; MSB of the return flags a hit.
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] elig,
                                              input logic [IDXW-1:0] last);
        logic [IDXW:0]   pick;
        logic [IDXW-1:0] idx;
        pick = {(IDXW+1){1'b0}};
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDXW'((int'(last) + k) % NREQ);
            if (elig[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    // A requester with an unconsumed result waits until its slot has been read.
    assign elig_s     = bus.req_valid & ~resp_valid_r;
    assign pick_s     = rr_pick(elig_s, rr_last_r);
    assign grant_ok_s = pick_s[IDXW];
    assign grant_s    = pick_s[IDXW-1:0];

    // Accept strobe: only while idle, and only for the winning requester.
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        if ((state_r == ST_IDLE) && grant_ok_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
    end

    alu_share_arbiter_alu u_alu (
        .srca   (op_srca_r),
        .srcb   (op_srcb_r),
        .fun    (op_fun_r),
        .result (alu_result_s)
    );

    // Arbitration FSM, operand latch, result slots and consume handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            rr_last_r     <= IDXW'(NREQ - 1);
            op_idx_r      <= {IDXW{1'b0}};
            op_srca_r     <= {DATA_W{1'b0}};
            op_srcb_r     <= {DATA_W{1'b0}};
            op_fun_r      <= {FUN_W{1'b0}};
            resp_valid_r  <= {NREQ{1'b0}};
            resp_result_r <= {(NREQ*DATA_W){1'b0}};
            busy_r        <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (resp_valid_r[i] && bus.resp_ready[i]) begin
                    resp_valid_r[i] <= 1'b0;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (grant_ok_s) begin
                        op_srca_r <= bus.req_srca[grant_s];
                        op_srcb_r <= bus.req_srcb[grant_s];
                        op_fun_r  <= bus.req_fun[grant_s];
                        op_idx_r  <= grant_s;
                        rr_last_r <= grant_s;
                        state_r   <= ST_EXEC;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    resp_result_r[op_idx_r] <= alu_result_s;
                    resp_valid_r[op_idx_r]  <= 1'b1;
                    state_r                 <= ST_IDLE;
                    busy_r                  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_result = resp_result_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;

    localparam int NREQ = 2;

    logic clk;
    logic rst;
    logic busy;

    alu_share_arbiter_if #(.NREQ(NREQ)) bus ();

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: is an op in flight, which requester, its result, and the slots.
    bit        m_busy;
    int        m_op;
    bit [31:0] m_res;
    int        m_last;
    bit        m_rv [NREQ];
    bit [31:0] m_rr [NREQ];
    int        grants [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] ref_alu(input bit [3:0] f, input bit [31:0] a, input bit [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f)
            4'd0:  return a + b;
            4'd1:  return a << sh;
            4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return a >> sh;
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd8:  return a - b;
            4'd9:  return a & 32'hFFFFF000;
            4'd13: return $signed(a) >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    // Requester the model would grant now, or -1.
    function automatic int model_pick();
        int i;
        if (m_busy) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            i = (m_last + k) % NREQ;
            if (bus.req_valid[i] && !m_rv[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_op   = 0;
        m_res  = 32'd0;
        m_last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            m_rv[i] = 1'b0;
            m_rr[i] = 32'd0;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int g;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rv;
        @(negedge clk);
        g = model_pick();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        for (int i = 0; i < NREQ; i++) exp_rv[i] = m_rv[i];
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(m_busy));
        check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
        for (int i = 0; i < NREQ; i++) check("resp_result", bus.resp_result[i], m_rr[i]);
        if (bus.req_ready != '0) grants.push_back(g);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NREQ; i++) if (m_rv[i] && bus.resp_ready[i]) m_rv[i] = 1'b0;
            if (m_busy) begin
                m_rv[m_op] = 1'b1;
                m_rr[m_op] = m_res;
                m_busy = 1'b0;
            end else if (g >= 0) begin
                m_busy = 1'b1;
                m_op   = g;
                m_res  = ref_alu(bus.req_fun[g], bus.req_srca[g], bus.req_srcb[g]);
                m_last = g;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        bus.req_srca   = '0;
        bus.req_srcb   = '0;
        bus.req_fun    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Issue one op from requester idx, wait for its result, check it, then consume.
    task automatic do_op(input int idx, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input string name);
        bit got;
        bus.req_srca[idx]  = a;
        bus.req_srcb[idx]  = b;
        bus.req_fun[idx]   = f;
        bus.req_valid[idx] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            #1;
            if (bus.req_ready[idx]) got = 1'b1;
            else cycle();
        end
        check({name, "_granted"}, 32'(got), 32'd1);
        cycle();
        bus.req_valid[idx] = 1'b0;
        cycle();
        check({name, "_valid"}, 32'(bus.resp_valid[idx]), 32'd1);
        check(name, bus.resp_result[idx], exp);
        bus.resp_ready[idx] = 1'b1;
        cycle();
        bus.resp_ready[idx] = 1'b0;
    endtask

    initial begin
        int ones;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        cycle();
        rst = 1'b0;

        // Reset values
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result0", bus.resp_result[0], 32'd0);

        // Single ADD: one-cycle accept, result two cycles later, held until consumed
        bus.req_srca[0] = 32'd5; bus.req_srcb[0] = 32'd7; bus.req_fun[0] = 4'd0;
        bus.req_valid[0] = 1'b1;
        #1;
        check("add_ready", 32'(bus.req_ready), 32'd1);
        cycle();
        bus.req_valid[0] = 1'b0;
        check("add_ready_drop", 32'(bus.req_ready), 32'd0);
        check("add_busy", 32'(busy), 32'd1);
        check("add_not_yet", 32'(bus.resp_valid), 32'd0);
        cycle();
        check("add_valid", 32'(bus.resp_valid), 32'd1);
        check("add_result", bus.resp_result[0], 32'd12);
        repeat (3) cycle();
        check("add_held", bus.resp_result[0], 32'd12);
        check("add_held_valid", 32'(bus.resp_valid), 32'd1);
        bus.resp_ready[0] = 1'b1;
        cycle();
        check("add_consumed", 32'(bus.resp_valid), 32'd0);
        check("add_after_consume", bus.resp_result[0], 32'd12);

        // Alternating grants with both requesters always valid
        do_reset();
        grants.delete();
        bus.resp_ready = 2'b11;
        bus.req_srca[0] = 32'd100; bus.req_srcb[0] = 32'd1; bus.req_fun[0] = 4'd0;
        bus.req_srca[1] = 32'd3;   bus.req_srcb[1] = 32'd5; bus.req_fun[1] = 4'd8;
        bus.req_valid = 2'b11;
        repeat (10) cycle();
        check("alt_count", 32'(grants.size()), 32'd5);
        check("alt_g0", 32'(grants[0]), 32'd0);
        check("alt_g1", 32'(grants[1]), 32'd1);
        check("alt_g2", 32'(grants[2]), 32'd0);
        check("alt_g3", 32'(grants[3]), 32'd1);
        check("sub_result", bus.resp_result[1], 32'hFFFFFFFE);
        check("add101_result", bus.resp_result[0], 32'd101);

        // Pending slot 1 blocks requester 1
        do_reset();
        grants.delete();
        bus.resp_ready = 2'b01;
        bus.req_valid = 2'b11;
        repeat (14) cycle();
        ones = 0;
        foreach (grants[i]) if (grants[i] == 1) ones++;
        check("block_req1_once", 32'(ones), 32'd1);
        check("block_first", 32'(grants[0]), 32'd0);
        bus.resp_ready = 2'b11;
        #1;
        check("block_release_same_cycle", 32'(bus.req_ready[1]), 32'd0);
        repeat (4) cycle();
        check("block_release_later", 32'(bus.resp_valid[1] | bus.req_ready[1] | busy), 32'd1);
        idle_inputs();
        repeat (3) cycle();

        // Shifts, comparisons, LUI, undefined code
        do_reset();
        do_op(0, 4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000, "sra");
        do_op(1, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'd1, "slt");
        do_op(0, 4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'd0, "sltu");
        do_op(1, 4'b1001, 32'h12345678, 32'h0, 32'h12345000, "lui");
        do_op(0, 4'b0001, 32'h00000003, 32'h00000021, 32'h00000006, "sll");
        do_op(1, 4'b1111, 32'hDEADBEEF, 32'h1, 32'd0, "undef");

        // Reset while executing
        do_reset();
        bus.req_srca[0] = 32'd1; bus.req_srcb[0] = 32'd1; bus.req_valid[0] = 1'b1;
        cycle();
        check("exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_rv", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 2'b11;
        #1;
        check("rst_exec_first_grant", 32'(bus.req_ready), 32'd1);
        cycle();

        // Requester 1 withdraws before being granted
        bus.req_valid = 2'b10;
        cycle();
        bus.req_valid = 2'b00;
        repeat (4) cycle();
        check("withdraw_no_resp", 32'(bus.resp_valid), 32'd1);

        // Randomized traffic with occasional reset
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bus.req_valid  = NREQ'($urandom);
            bus.resp_ready = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                bus.req_srca[i] = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
                bus.req_srcb[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                bus.req_fun[i]  = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
